// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline control chain
package pipe_pkg;

    localparam int PIPE_PAYLOAD_W  = 32;
    localparam int PIPE_REG_ADDR_W = 4;

    localparam int STG_ID  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                       valid;
        logic                       wr;
        logic                       load;
        logic                       use1;
        logic                       use2;
        logic [PIPE_REG_ADDR_W-1:0] src1;
        logic [PIPE_REG_ADDR_W-1:0] src2;
        logic [PIPE_REG_ADDR_W-1:0] dst;
        logic [PIPE_PAYLOAD_W-1:0]  payload;
    } stage_t;

    // True when stage s will write register r (register 0 never counts).
    function automatic logic produces(stage_t s, logic [PIPE_REG_ADDR_W-1:0] r);
        return s.valid && s.wr && (s.dst != '0) && (s.dst == r);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one inter-stage latch with hold and bubble control
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    // Hold beats bubble; a bubble clears every field so no stale wr/load leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - pipeline latches with stall, flush, load-use interlock and forwarding
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    // Field widths are carried in the package stage_t; keep these equal to it.
    parameter int PAYLOAD_W  = PIPE_PAYLOAD_W,
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
    parameter int NUM_STAGES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            if_valid,
    input  logic [PAYLOAD_W-1:0]            if_payload,
    input  logic [REG_ADDR_W-1:0]           if_src1,
    input  logic [REG_ADDR_W-1:0]           if_src2,
    input  logic                            if_use1,
    input  logic                            if_use2,
    input  logic [REG_ADDR_W-1:0]           if_dst,
    input  logic                            if_wr,
    input  logic                            if_load,
    input  logic                            branch_taken,
    input  logic                            ext_stall,
    output logic                            fetch_stall,
    output logic [NUM_STAGES-1:0]           stage_valid,
    output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload,
    output logic [1:0]                      fwd_sel_a,
    output logic [1:0]                      fwd_sel_b,
    output logic                            wb_valid,
    output logic [REG_ADDR_W-1:0]           wb_dst
);

    localparam int STG_WB = NUM_STAGES - 1;

    stage_t                stg_q [NUM_STAGES];
    stage_t                if_stage;
    logic [NUM_STAGES-1:0] stg_hold;
    logic [NUM_STAGES-1:0] stg_bubble;
    logic                  load_use;
    logic                  flush;
    logic                  hazard;
    fwd_sel_t              fwd_a;
    fwd_sel_t              fwd_b;

    // Pack the fetch side into a stage record; an invalid fetch becomes a clean bubble.
    always_comb begin
        if_stage = '0;
        if (if_valid) begin
            if_stage.valid   = 1'b1;
            if_stage.wr      = if_wr;
            if_stage.load    = if_load;
            if_stage.use1    = if_use1;
            if_stage.use2    = if_use2;
            if_stage.src1    = if_src1;
            if_stage.src2    = if_src2;
            if_stage.dst     = if_dst;
            if_stage.payload = if_payload;
        end
    end

    // Load in EX whose result a source of the instruction in ID needs right away.
    always_comb begin
        load_use = stg_q[STG_EX].load && stg_q[STG_ID].valid &&
                   ((stg_q[STG_ID].use1 && produces(stg_q[STG_EX], stg_q[STG_ID].src1)) ||
                    (stg_q[STG_ID].use2 && produces(stg_q[STG_EX], stg_q[STG_ID].src2)));
    end

    assign flush       = branch_taken && stg_q[STG_EX].valid && !ext_stall;
    assign hazard      = load_use && !ext_stall && !flush;
    assign fetch_stall = ext_stall || hazard;

    // Per-stage control: freeze everything on ext_stall, otherwise flush or interlock the front.
    always_comb begin
        stg_hold             = {NUM_STAGES{ext_stall}};
        stg_bubble           = '0;
        stg_hold[STG_ID]     = ext_stall || hazard;
        stg_bubble[STG_ID]   = flush;
        stg_bubble[STG_EX]   = flush || hazard;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        stage_t d;
        if (g == STG_ID) begin : g_head
            assign d = if_stage;
        end else begin : g_tail
            assign d = stg_q[g-1];
        end

        pipe_stage_reg u_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (stg_hold[g]),
            .bubble (stg_bubble[g]),
            .d      (d),
            .q      (stg_q[g])
        );

        assign stage_valid[g]                          = stg_q[g].valid;
        assign stage_payload[g*PAYLOAD_W +: PAYLOAD_W] = stg_q[g].payload;
    end

    // EX operand sources: MEM is newer than WB, so it is checked first.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (stg_q[STG_EX].valid && stg_q[STG_EX].use1) begin
            if (produces(stg_q[STG_MEM], stg_q[STG_EX].src1)) begin
                fwd_a = FWD_MEM;
            end else if (produces(stg_q[STG_WB], stg_q[STG_EX].src1)) begin
                fwd_a = FWD_WB;
            end
        end
        if (stg_q[STG_EX].valid && stg_q[STG_EX].use2) begin
            if (produces(stg_q[STG_MEM], stg_q[STG_EX].src2)) begin
                fwd_b = FWD_MEM;
            end else if (produces(stg_q[STG_WB], stg_q[STG_EX].src2)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    assign fwd_sel_a = fwd_a;
    assign fwd_sel_b = fwd_b;
    assign wb_valid  = stg_q[STG_WB].valid && stg_q[STG_WB].wr;
    assign wb_dst    = stg_q[STG_WB].dst;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - directed self-checking bench for pipe_ctrl_chain
module tb_pipe_ctrl_chain;

    localparam int PW = 32;
    localparam int RW = 4;
    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           if_valid;
    logic [PW-1:0]  if_payload;
    logic [RW-1:0]  if_src1;
    logic [RW-1:0]  if_src2;
    logic           if_use1;
    logic           if_use2;
    logic [RW-1:0]  if_dst;
    logic           if_wr;
    logic           if_load;
    logic           branch_taken;
    logic           ext_stall;
    logic           fetch_stall;
    logic [NS-1:0]  stage_valid;
    logic [NS*PW-1:0] stage_payload;
    logic [1:0]     fwd_sel_a;
    logic [1:0]     fwd_sel_b;
    logic           wb_valid;
    logic [RW-1:0]  wb_dst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(.PAYLOAD_W(PW), .REG_ADDR_W(RW), .NUM_STAGES(NS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_payload    (if_payload),
        .if_src1       (if_src1),
        .if_src2       (if_src2),
        .if_use1       (if_use1),
        .if_use2       (if_use2),
        .if_dst        (if_dst),
        .if_wr         (if_wr),
        .if_load       (if_load),
        .branch_taken  (branch_taken),
        .ext_stall     (ext_stall),
        .fetch_stall   (fetch_stall),
        .stage_valid   (stage_valid),
        .stage_payload (stage_payload),
        .fwd_sel_a     (fwd_sel_a),
        .fwd_sel_b     (fwd_sel_b),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst)
    );

    // Behavioural model: a list of NS instruction slots, index 0 = ID.
    typedef struct packed {
        bit          v;
        bit          wr;
        bit          ld;
        bit          u1;
        bit          u2;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [31:0] p;
    } ent_t;

    ent_t m [NS];
    ent_t inc;
    bit   exp_fs;

    function automatic bit writes(ent_t e, logic [3:0] r);
        return e.v && e.wr && (e.d != 4'd0) && (e.d == r);
    endfunction

    function automatic bit lu();
        return m[1].ld && m[0].v &&
               ((m[0].u1 && writes(m[1], m[0].s1)) || (m[0].u2 && writes(m[1], m[0].s2)));
    endfunction

    function automatic logic [1:0] fsel(bit u, logic [3:0] s);
        if (!m[1].v || !u) return 2'd0;
        if (writes(m[2], s)) return 2'd1;
        if (writes(m[NS-1], s)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        inc = '0;
        if (if_valid) begin
            inc.v  = 1'b1;
            inc.wr = if_wr;
            inc.ld = if_load;
            inc.u1 = if_use1;
            inc.u2 = if_use2;
            inc.s1 = if_src1;
            inc.s2 = if_src2;
            inc.d  = if_dst;
            inc.p  = if_payload;
        end
    end

    assign exp_fs = ext_stall || (!(branch_taken && m[1].v) && lu());

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) m[i] <= '0;
        end else if (!ext_stall) begin
            if (branch_taken && m[1].v) begin
                for (int i = NS-1; i >= 2; i--) m[i] <= m[i-1];
                m[1] <= '0;
                m[0] <= '0;
            end else if (lu()) begin
                for (int i = NS-1; i >= 2; i--) m[i] <= m[i-1];
                m[1] <= '0;
            end else begin
                for (int i = NS-1; i >= 1; i--) m[i] <= m[i-1];
                m[0] <= inc;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_fetch_stall", 32'(fetch_stall), 32'(exp_fs));
        for (int i = 0; i < NS; i++) begin
            chk("cmp_valid", 32'(stage_valid[i]), 32'(m[i].v));
            chk("cmp_payload", stage_payload[i*PW +: PW], m[i].p);
        end
        chk("cmp_fwd_a", 32'(fwd_sel_a), 32'(fsel(m[1].u1, m[1].s1)));
        chk("cmp_fwd_b", 32'(fwd_sel_b), 32'(fsel(m[1].u2, m[1].s2)));
        chk("cmp_wb_valid", 32'(wb_valid), 32'(m[NS-1].v && m[NS-1].wr));
        chk("cmp_wb_dst", 32'(wb_dst), 32'(m[NS-1].d));
    end

    task automatic drive(bit v, logic [31:0] p, logic [3:0] s1, bit u1, logic [3:0] s2, bit u2,
                         logic [3:0] d, bit wr, bit ld);
        if_valid   = v;
        if_payload = p;
        if_src1    = s1;
        if_use1    = u1;
        if_src2    = s2;
        if_use2    = u2;
        if_dst     = d;
        if_wr      = wr;
        if_load    = ld;
    endtask

    task automatic idle();
        drive(0, 32'h0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (NS) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        branch_taken = 1'b0;
        ext_stall    = 1'b0;
        rst_n        = 1'b0;
        repeat (2) step();
        look();
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_fetch_stall", 32'(fetch_stall), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_fwd_a", 32'(fwd_sel_a), 32'h0);
        rst_n = 1'b1;

        // Independent ALU ops: each reaches WB three edges after entering ID.
        for (int k = 1; k <= 9; k++) begin
            if (k <= 6) drive(1, 32'h100 + k, 4'd0, 0, 4'd0, 0, 4'(k), 1, 0);
            else idle();
            step();
            if (k >= 4) begin
                look();
                chk("alu_wb_dst", 32'(wb_dst), k - 3);
                chk("alu_wb_valid", 32'(wb_valid), 32'h1);
            end
        end
        drain();

        // Back-to-back dependency forwards from MEM.
        drive(1, 32'h31, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0); step();
        drive(1, 32'h32, 4'd3, 1, 4'd0, 0, 4'd7, 1, 0); step();
        idle(); step(); look();
        chk("fwd_mem_a", 32'(fwd_sel_a), 32'h1);
        drain();

        // One instruction in between forwards from WB.
        drive(1, 32'h33, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0); step();
        drive(1, 32'h34, 4'd0, 0, 4'd0, 0, 4'd8, 1, 0); step();
        drive(1, 32'h35, 4'd3, 1, 4'd0, 0, 4'd7, 1, 0); step();
        idle(); step(); look();
        chk("fwd_wb_a", 32'(fwd_sel_a), 32'h2);
        drain();

        // Register 0 never forwards.
        drive(1, 32'h36, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0); step();
        drive(1, 32'h37, 4'd0, 1, 4'd0, 0, 4'd7, 1, 0); step();
        idle(); step(); look();
        chk("fwd_r0_a", 32'(fwd_sel_a), 32'h0);
        drain();

        // Load-use: one stall cycle, bubble in EX, then WB forward on src2.
        drive(1, 32'h51, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1); step();
        drive(1, 32'h52, 4'd0, 0, 4'd5, 1, 4'd9, 1, 0); step();
        look();
        chk("lu_fetch_stall", 32'(fetch_stall), 32'h1);
        drive(1, 32'h53, 4'd0, 0, 4'd0, 0, 4'd10, 1, 0); step();
        look();
        chk("lu_valid", 32'(stage_valid), 32'h5);
        chk("lu_fetch_clear", 32'(fetch_stall), 32'h0);
        chk("lu_id_hold", stage_payload[31:0], 32'h52);
        step(); idle(); look();
        chk("lu_fwd_b", 32'(fwd_sel_b), 32'h2);
        chk("lu_valid_after", 32'(stage_valid), 32'hB);
        drain();

        // Branch flush beats a simultaneous load-use hazard.
        drive(1, 32'hB0, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1); step();
        drive(1, 32'hB1, 4'd5, 1, 4'd0, 0, 4'd9, 1, 0); step();
        branch_taken = 1'b1;
        drive(1, 32'hB2, 4'd0, 0, 4'd0, 0, 4'd12, 1, 0);
        look();
        chk("br_fetch_stall", 32'(fetch_stall), 32'h0);
        step();
        branch_taken = 1'b0;
        idle();
        look();
        chk("br_valid", 32'(stage_valid), 32'h4);
        chk("br_mem_payload", stage_payload[95:64], 32'hB0);
        drain();

        // ext_stall freezes a full pipe; a pending branch acts on the first free edge.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 32'h200 + k, 4'd0, 0, 4'd0, 0, 4'(k), 1, 0);
            step();
        end
        ext_stall    = 1'b1;
        branch_taken = 1'b1;
        drive(1, 32'h2FF, 4'd0, 0, 4'd0, 0, 4'd13, 1, 0);
        look();
        chk("st_full", 32'(stage_valid), 32'hF);
        chk("st_fetch_stall", 32'(fetch_stall), 32'h1);
        repeat (3) begin
            step(); look();
            chk("st_valid", 32'(stage_valid), 32'hF);
            chk("st_wb_dst", 32'(wb_dst), 32'h1);
            chk("st_ex_payload", stage_payload[63:32], 32'h203);
        end
        ext_stall = 1'b0;
        #1;
        chk("st_release_fs", 32'(fetch_stall), 32'h0);
        step();
        branch_taken = 1'b0;
        idle();
        look();
        chk("st_br_valid", 32'(stage_valid), 32'hC);
        chk("st_br_wb_dst", 32'(wb_dst), 32'h2);
        chk("st_br_mem_payload", stage_payload[95:64], 32'h203);
        drain();

        // Short asynchronous reset mid-stream.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 32'h300 + k, 4'd0, 0, 4'd0, 0, 4'(k), 1, 0);
            step();
        end
        idle();
        look();
        chk("ar_pre_wb_valid", 32'(wb_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(stage_valid), 32'h0);
        chk("ar_wb_valid", 32'(wb_valid), 32'h0);
        #1;
        rst_n = 1'b1;
        drive(1, 32'h3AA, 4'd0, 0, 4'd0, 0, 4'd11, 1, 0); step();
        idle();
        step(); step(); step();
        look();
        chk("ar_first_wb_dst", 32'(wb_dst), 32'hB);
        chk("ar_first_wb_valid", 32'(wb_valid), 32'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
